// File: rtl/imm_fragmenter_pkg.sv
// Shared definitions for the immediate fragmenter and its helpers.
//   - fragment opcodes (LOAD / SHIFT_OR)
//   - fragmenter FSM state encoding
//   - value length classes produced by imm_classifier
package imm_fragmenter_pkg;

   localparam int unsigned IMM_W  = 3;
   localparam int unsigned DATA_W = 8;

   localparam logic OP_LOAD     = 1'b0;  // acc = sext(imm)
   localparam logic OP_SHIFT_OR = 1'b1;  // acc = (acc << 3) | imm

   // The state names the fragment currently presented on the output.
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      EMIT_HI  = 2'd1,
      EMIT_MID = 2'd2,
      EMIT_LO  = 2'd3
   } state_e;

   // Number of 3-bit fragments needed to rebuild a value: 1, 2 or 3.
   typedef enum logic [1:0] {
      CLS_SHORT = 2'd0,
      CLS_MID   = 2'd1,
      CLS_LONG  = 2'd2
   } cls_e;

endpackage

// File: rtl/imm_fragmenter_if.sv
// Handshake bundle between constant source, fragmenter and issue stage.
//   in_valid/in_ready/in_data        : 8-bit constant input
//   out_valid/out_ready/out_imm/
//   out_op/out_last                  : fragment output
// slave  : the fragmenter side; master : the source/consumer side.
interface imm_fragmenter_if;
   import imm_fragmenter_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [IMM_W-1:0]  out_imm;
   logic              out_op;
   logic              out_last;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_imm, out_op, out_last
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_imm, out_op, out_last
   );

endinterface

// File: rtl/imm_classifier.sv
// Combinational length classifier for 8-bit two's-complement constants.
//   v   : value to classify
//   cls : CLS_SHORT if v fits a signed 3-bit immediate, CLS_MID if it fits
//         6 bits, CLS_LONG otherwise
module imm_classifier
   import imm_fragmenter_pkg::*;
(
   input  logic [DATA_W-1:0] v,
   output cls_e              cls
);

   logic short_fit;
   logic mid_fit;

   // A value fits N signed bits when every bit from N-1 upward is a copy of the sign.
   assign short_fit = (&v[7:2]) | ~(|v[7:2]);
   assign mid_fit   = (&v[7:5]) | ~(|v[7:5]);

   always_comb begin
      cls = CLS_LONG;
      if (short_fit) begin
         cls = CLS_SHORT;
      end else if (mid_fit) begin
         cls = CLS_MID;
      end
   end

endmodule

// File: rtl/imm_fragmenter.sv
// Splits 8-bit constants into the shortest run of 3-bit immediate fragments
// that the issue side rebuilds with sign-extend / shift-left-3 / OR.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : input constant handshake and fragment output handshake
//   val_cnt    : number of values accepted (wraps)
//   frag_cnt   : number of fragments accepted by the consumer (wraps)
module imm_fragmenter
   import imm_fragmenter_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   imm_fragmenter_if.slave      bus,
   output logic [CNT_W-1:0]     val_cnt,
   output logic [CNT_W-1:0]     frag_cnt
);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic              first_q, first_d;   // current fragment is the value's LOAD
   cls_e              in_cls;
   logic              take;
   logic              fire;

   imm_classifier u_classifier (
      .v   (bus.in_data),
      .cls (in_cls)
   );

   always_comb begin
      bus.out_valid = (state_q != IDLE);
      bus.out_last  = (state_q == EMIT_LO);
      bus.out_op    = (state_q == IDLE || first_q) ? OP_LOAD : OP_SHIFT_OR;
      bus.out_imm   = '0;
      unique case (state_q)
         EMIT_HI:  bus.out_imm = {hold_q[7], hold_q[7], hold_q[6]};
         EMIT_MID: bus.out_imm = hold_q[5:3];
         EMIT_LO:  bus.out_imm = hold_q[2:0];
         default:  bus.out_imm = '0;
      endcase
      // A new value may enter while the last fragment of the old one leaves.
      bus.in_ready = !bus.out_valid || (bus.out_ready && bus.out_last);
   end

   assign take = bus.in_valid && bus.in_ready;
   assign fire = bus.out_valid && bus.out_ready;

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      first_d = first_q;
      if (take) begin
         hold_d  = bus.in_data;
         first_d = 1'b1;
         unique case (in_cls)
            CLS_SHORT: state_d = EMIT_LO;
            CLS_MID:   state_d = EMIT_MID;
            default:   state_d = EMIT_HI;
         endcase
      end else if (fire) begin
         first_d = 1'b0;
         unique case (state_q)
            EMIT_HI:  state_d = EMIT_MID;
            EMIT_MID: state_d = EMIT_LO;
            default:  state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         hold_q   <= '0;
         first_q  <= 1'b0;
         val_cnt  <= '0;
         frag_cnt <= '0;
      end else begin
         state_q  <= state_d;
         hold_q   <= hold_d;
         first_q  <= first_d;
         val_cnt  <= val_cnt + {{(CNT_W-1){1'b0}}, take};
         frag_cnt <= frag_cnt + {{(CNT_W-1){1'b0}}, fire};
      end
   end

endmodule

// File: tb/tb_imm_fragmenter.sv
module tb_imm_fragmenter;
   import imm_fragmenter_pkg::*;

   localparam int unsigned CNT_W = 16;

   typedef struct {
      logic [7:0]       data;
      int               nfrag;
      logic [2:0][2:0]  imm;    // imm[k] = expected k-th fragment
   } vec_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [CNT_W-1:0] val_cnt;
   logic [CNT_W-1:0] frag_cnt;

   imm_fragmenter_if bus ();

   imm_fragmenter #(.CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .val_cnt  (val_cnt),
      .frag_cnt (frag_cnt)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_tot  = 0;
   int exp_val = 0;
   int exp_frag = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   function automatic vec_t mk(input logic [7:0] d, input int n,
                               input logic [2:0] i0, input logic [2:0] i1, input logic [2:0] i2);
      vec_t t;
      t.data = d;
      t.nfrag = n;
      t.imm[0] = i0;
      t.imm[1] = i1;
      t.imm[2] = i2;
      return t;
   endfunction

   // Single value from idle with the consumer always ready.
   task automatic send_vec(input vec_t t);
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_data = t.data;
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("in_ready_idle v=%02h", t.data), bus.in_ready, 1);
      @(posedge clk);
      exp_val++;
      #1 bus.in_valid = 1'b0;
      for (int k = 0; k < t.nfrag; k++) begin
         @(negedge clk);
         chk($sformatf("valid v=%02h f%0d", t.data, k), bus.out_valid, 1);
         chk($sformatf("imm v=%02h f%0d", t.data, k), bus.out_imm, t.imm[k]);
         chk($sformatf("op v=%02h f%0d", t.data, k), bus.out_op, (k != 0));
         chk($sformatf("last v=%02h f%0d", t.data, k), bus.out_last, (k == t.nfrag - 1));
         chk($sformatf("in_ready v=%02h f%0d", t.data, k), bus.in_ready, (k == t.nfrag - 1));
         @(posedge clk);
         exp_frag++;
      end
      @(negedge clk);
      chk($sformatf("idle v=%02h", t.data), bus.out_valid, 0);
      chk($sformatf("val_cnt v=%02h", t.data), val_cnt, exp_val);
      chk($sformatf("frag_cnt v=%02h", t.data), frag_cnt, exp_frag);
   endtask

   vec_t vecs[$];
   int   order[256];

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.out_ready = 1'b1;

      // Reset state
      #12;
      chk("rst out_valid", bus.out_valid, 0);
      chk("rst out_imm", bus.out_imm, 0);
      chk("rst out_op", bus.out_op, 0);
      chk("rst out_last", bus.out_last, 0);
      chk("rst val_cnt", val_cnt, 0);
      chk("rst frag_cnt", frag_cnt, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Table of single values with hand-derived fragments
      vecs.push_back(mk(8'h02, 1, 3'b010, 3'b000, 3'b000));
      vecs.push_back(mk(8'hFD, 1, 3'b101, 3'b000, 3'b000));
      vecs.push_back(mk(8'h03, 1, 3'b011, 3'b000, 3'b000));
      vecs.push_back(mk(8'hFC, 1, 3'b100, 3'b000, 3'b000));
      vecs.push_back(mk(8'h1A, 2, 3'b011, 3'b010, 3'b000));
      vecs.push_back(mk(8'h04, 2, 3'b000, 3'b100, 3'b000));
      vecs.push_back(mk(8'hE0, 2, 3'b100, 3'b000, 3'b000));
      vecs.push_back(mk(8'hA5, 3, 3'b110, 3'b100, 3'b101));
      vecs.push_back(mk(8'h7F, 3, 3'b001, 3'b111, 3'b111));
      vecs.push_back(mk(8'h80, 3, 3'b110, 3'b000, 3'b000));
      foreach (vecs[i]) send_vec(vecs[i]);

      // Back-to-back SHORT values: second accepted as the first is consumed
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_data = 8'hFD;
      @(posedge clk);
      exp_val++;
      #1 bus.in_data = 8'h02;
      @(negedge clk);
      chk("b2b first imm", bus.out_imm, 3'b101);
      chk("b2b first last", bus.out_last, 1);
      chk("b2b in_ready", bus.in_ready, 1);
      @(posedge clk);
      exp_val++;
      exp_frag++;
      #1 bus.in_valid = 1'b0;
      @(negedge clk);
      chk("b2b second valid", bus.out_valid, 1);
      chk("b2b second imm", bus.out_imm, 3'b010);
      chk("b2b second op", bus.out_op, 0);
      chk("b2b val_cnt", val_cnt, exp_val);
      chk("b2b frag_cnt", frag_cnt, exp_frag);
      @(posedge clk);
      exp_frag++;
      @(negedge clk);
      chk("b2b idle", bus.out_valid, 0);

      // Backpressure on the second fragment of 0xA5
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_data = 8'hA5;
      @(posedge clk);
      exp_val++;
      #1 bus.in_valid = 1'b0;
      @(negedge clk);
      chk("bp first imm", bus.out_imm, 3'b110);
      @(posedge clk);
      exp_frag++;
      #1;
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data = 8'h02;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("bp hold valid c%0d", c), bus.out_valid, 1);
         chk($sformatf("bp hold imm c%0d", c), bus.out_imm, 3'b100);
         chk($sformatf("bp hold op c%0d", c), bus.out_op, 1);
         chk($sformatf("bp hold last c%0d", c), bus.out_last, 0);
         chk($sformatf("bp in_ready c%0d", c), bus.in_ready, 0);
         chk($sformatf("bp frag_cnt c%0d", c), frag_cnt, exp_frag);
         chk($sformatf("bp val_cnt c%0d", c), val_cnt, exp_val);
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("bp release imm", bus.out_imm, 3'b100);
      @(posedge clk);
      exp_frag++;
      @(negedge clk);
      chk("bp third imm", bus.out_imm, 3'b101);
      chk("bp third last", bus.out_last, 1);
      @(posedge clk);
      exp_frag++;
      @(negedge clk);
      chk("bp idle", bus.out_valid, 0);
      chk("bp frag_cnt end", frag_cnt, exp_frag);

      // Reset during the second fragment of 0x80
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_data = 8'h80;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(posedge clk); #2;
      chk("rstmid pre imm", bus.out_imm, 3'b000);
      chk("rstmid pre op", bus.out_op, 1);
      rst_n = 1'b0;
      #1;
      chk("rstmid out_valid", bus.out_valid, 0);
      chk("rstmid out_last", bus.out_last, 0);
      chk("rstmid val_cnt", val_cnt, 0);
      chk("rstmid frag_cnt", frag_cnt, 0);
      exp_val = 0;
      exp_frag = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rstmid no stale", bus.out_valid, 0);
      send_vec(mk(8'h01, 1, 3'b001, 3'b000, 3'b000));

      // Shuffled sweep of all values with random consumer stalls
      for (int i = 0; i < 256; i++) order[i] = i;
      for (int i = 255; i > 0; i--) begin
         int j;
         int tmp;
         j = $urandom_range(i, 0);
         tmp = order[i];
         order[i] = order[j];
         order[j] = tmp;
      end
      for (int i = 0; i < 256; i++) begin
         logic [7:0] v;
         logic [7:0] acc;
         int         nf;
         int         want_n;
         bit         done;
         bit         bad;
         v = order[i][7:0];
         if ($signed(v) >= -4 && $signed(v) <= 3) want_n = 1;
         else if ($signed(v) >= -32 && $signed(v) <= 31) want_n = 2;
         else want_n = 3;
         @(posedge clk); #1;
         bus.in_valid = 1'b1;
         bus.in_data = v;
         @(posedge clk);
         exp_val++;
         #1 bus.in_valid = 1'b0;
         acc = '0;
         nf = 0;
         done = 1'b0;
         bad = 1'b0;
         for (int c = 0; c < 40 && !done; c++) begin
            bus.out_ready = ($urandom_range(3, 0) != 0);
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
               if (bus.out_op != (nf != 0)) bad = 1'b1;
               if (bus.out_op) acc = {acc[4:0], bus.out_imm};
               else acc = {{5{bus.out_imm[2]}}, bus.out_imm};
               nf++;
               exp_frag++;
               if (bus.out_last) done = 1'b1;
            end
            @(posedge clk); #1;
         end
         if (!done) begin
            n_tot++;
            $display("FAIL sweep timeout v=%02h: no last fragment within 40 cycles", v);
         end
         chk($sformatf("sweep acc v=%02h", v), acc, v);
         chk($sformatf("sweep nfrag v=%02h", v), nf, want_n);
         chk($sformatf("sweep ops v=%02h", v), bad, 0);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("sweep val_cnt", val_cnt, exp_val);
      chk("sweep frag_cnt", frag_cnt, exp_frag);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/imm_fragmenter.md
Name: imm_fragmenter

Overview:
- Inverse of the datapath's 3-bit signed-immediate extender.
- Accepts 8-bit constants and breaks each one into the shortest sequence of 3-bit immediate fragments.
- The decode/ALU side rebuilds the constant from these fragments using only sign-extension, shift-left-by-3 and OR.
- Sits between the program/constant source and the instruction-issue stage, with valid/ready handshakes on both sides.

Parameters:
- CNT_W, 16: width of the accepted-value and emitted-fragment statistics counters.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a value this cycle.
- in_data  input  8  two's-complement constant to fragment.
- out_valid  output  1  a fragment is presented.
- out_ready  input  1  consumer accepts the fragment this cycle.
- out_imm  output  3  fragment payload.
- out_op  output  1  0 = LOAD (acc = sext(imm)); 1 = SHIFT_OR (acc = (acc<<3) | {5'b0, imm}).
- out_last  output  1  this is the final fragment of the current value.
- val_cnt  output  CNT_W  number of values accepted.
- frag_cnt  output  CNT_W  number of fragments accepted by the consumer.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - out_valid=0, out_imm=0, out_op=0, out_last=0.
  - val_cnt=0, frag_cnt=0.
  - State = IDLE; the holding register is cleared.
- Reset mid-sequence: the remaining fragments are dropped and no partial output is emitted after release.
- Classification of an accepted value v:
  - SHORT: v[7:2] all equal. One fragment: LOAD v[2:0], last=1.
  - MID: v[7:5] all equal, not SHORT. Two fragments: LOAD v[5:3], then SHIFT_OR v[2:0] with last=1.
  - LONG: otherwise. Three fragments: LOAD {v[7],v[7],v[6]}, then SHIFT_OR v[5:3], then SHIFT_OR v[2:0] with last=1.
- Input handshake:
  - Transfer occurs when in_valid && in_ready.
  - in_ready = !out_valid || (out_ready && out_last).
  - Back-to-back SHORT values therefore stream at 1 per cycle.
- Latency: the first fragment appears on out_valid in the cycle after the input transfer (outputs are registered).
- FSM states: IDLE, EMIT_HI, EMIT_MID, EMIT_LO. The state names the fragment currently presented.
  - SHORT enters EMIT_LO; MID enters EMIT_MID; LONG enters EMIT_HI.
  - On out_valid && out_ready:
    - EMIT_HI -> EMIT_MID.
    - EMIT_MID -> EMIT_LO.
    - EMIT_LO -> IDLE, or directly to the next value's first state if a new input transfers in the same cycle.
- The value is latched in an 8-bit holding register on input transfer.
- out_op is 0 only for the first fragment of a value. out_last is 1 only in EMIT_LO.
- Backpressure: while out_valid && !out_ready, out_imm, out_op, out_last and the state hold stable, and in_ready stays 0.
- Counters:
  - val_cnt increments on each input transfer.
  - frag_cnt increments on each output transfer.
  - Both wrap modulo 2^CNT_W and may increment in the same cycle.
- Invariant: replaying the fragments through the acc rules yields exactly v.

Decomposition:
- Shared package holds:
  - OP_LOAD=1'b0 and OP_SHIFT_OR=1'b1.
  - The state encoding (IDLE/EMIT_HI/EMIT_MID/EMIT_LO).
  - IMM_W=3 and DATA_W=8.
- One natural sub-module: imm_classifier, a combinational block mapping 8-bit v to {SHORT, MID, LONG}, reusable by the assembler checker.
- The FSM, holding register and counters stay in the top module.

Test Plan:
- 0x02 with out_ready=1 -> one cycle later: LOAD 3'b010, last=1; val_cnt=1, frag_cnt=1.
- 0xFD -> LOAD 3'b101, last=1; next value accepted the same cycle the fragment is consumed.
- 0x1A -> LOAD 3'b011, then SHIFT_OR 3'b010 with last=1; in_ready=0 during the first fragment.
- 0xA5 -> LOAD 3'b110, SHIFT_OR 3'b100, SHIFT_OR 3'b101 last=1. Then 0x7F -> LOAD 3'b001, SHIFT_OR 3'b111, SHIFT_OR 3'b111 last=1.
- 0xA5 with out_ready held 0 for 3 cycles on the second fragment -> SHIFT_OR 3'b100 held stable, in_ready=0, frag_cnt unchanged until release.
- rst_n asserted during the second fragment of 0x80 -> out_valid=0 immediately, counters=0; after release, 0x01 yields LOAD 3'b001, last=1 with no stale fragments.
- Randomized sweep of all 256 values -> reconstructed acc equals the input in every case.
